// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared state encoding and default APB widths for the APB master arbiter
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;
endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: combinational round-robin pick starting the search at ptr
module apb_rr_arbiter #(
  parameter int N = 2,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          any
);
  // scan from the farthest slot back toward ptr so the nearest eligible slot is written last and wins
  always_comb begin
    winner = '0;
    any = |eligible;
    for (int k = N - 1; k >= 0; k--)
      if (eligible[(int'(ptr) + k) % N]) winner = IW'((int'(ptr) + k) % N);
    grant = any ? N'(1) << winner : '0;
  end
endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin APB master shared by several requesters, with wait-state timeout
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strb,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W/8-1:0]       pstrb,
  output logic [DATA_W-1:0]         pwdata,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [DATA_W-1:0]         prdata
);
  localparam int SW = DATA_W / 8;
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, pick;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_REQ-1:0] owner, owner_n, grant, eligible, rsp_valid_n;
  logic any, done, psel_n, penable_n, pwrite_n, rsp_err_n, busy_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n, rsp_rdata_n;
  logic [SW-1:0] pstrb_n;
  // the requester being answered this cycle still holds req, so it must not be re-granted
  assign eligible = req & ~rsp_valid;
  assign done = state == ACCESS && (pready || (TIMEOUT != 0 && cnt == CW'(TIMEOUT)));
  apb_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .eligible(eligible),
    .ptr(ptr),
    .grant(grant),
    .winner(pick),
    .any(any)
  );
  // next-state and next-output logic; every output is a register so values are computed one cycle ahead
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    owner_n = owner;
    psel_n = psel;
    penable_n = penable;
    pwrite_n = pwrite;
    paddr_n = paddr;
    pstrb_n = pstrb;
    pwdata_n = pwdata;
    rsp_valid_n = '0;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n = rsp_err;
    case (state)
      IDLE: if (any) begin
        state_n = SETUP;
        ptr_n = pick == IW'(NUM_REQ - 1) ? '0 : pick + 1'b1;
        owner_n = grant;
        psel_n = 1'b1;
        pwrite_n = req_write[pick];
        paddr_n = req_addr[int'(pick)*ADDR_W +: ADDR_W];
        pwdata_n = req_wdata[int'(pick)*DATA_W +: DATA_W];
        pstrb_n = req_write[pick] ? req_strb[int'(pick)*SW +: SW] : '0;
      end
      SETUP: begin
        state_n = ACCESS;
        penable_n = 1'b1;
      end
      ACCESS: if (done) begin
        state_n = IDLE;
        cnt_n = '0;
        psel_n = 1'b0;
        penable_n = 1'b0;
        rsp_valid_n = owner;
        rsp_err_n = pready ? pslverr : 1'b1;
        rsp_rdata_n = pready && !pwrite ? prdata : '0;
      end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
    busy_n = state_n != IDLE;
  end
  // state and output registers; reset abandons any transfer in flight without a response
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      owner <= '0;
      psel <= 1'b0;
      penable <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pstrb <= '0;
      pwdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      owner <= owner_n;
      psel <= psel_n;
      penable <= penable_n;
      pwrite <= pwrite_n;
      paddr <= paddr_n;
      pstrb <= pstrb_n;
      pwdata <= pwdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err <= rsp_err_n;
      busy <= busy_n;
    end
  end
endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

APB master controller that shares one APB bus (psel/penable/pwrite/paddr/pstrb/pwdata in; pready/pslverr/prdata back) between NUM_REQ on-chip requesters, for example the UART register test sequencer and the DMA/config engine. It arbitrates round-robin, runs a compliant SETUP→ACCESS sequence per transfer, and returns read data and error status to the winner. A wait-state timeout guarantees a hung slave cannot lock the bus.

## Interface
- NUM_REQ, 2: number of requesters (1..8)
- ADDR_W, 12: APB address width
- DATA_W, 32: APB data width
- TIMEOUT, 16: max ACCESS cycles with pready=0 before forced error; 0 = never time out
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester transfer request; held until that requester's rsp_valid
- req_write  in  NUM_REQ  1 = write
- req_addr  in  NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_strb  in  NUM_REQ*DATA_W/8  packed byte strobes
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester
- rsp_rdata  out  DATA_W  shared; valid with any rsp_valid bit
- rsp_err  out  1  shared; pslverr or timeout
- busy  out  1  FSM not IDLE
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W; pstrb  out  DATA_W/8; pwdata  out  DATA_W
- pready, pslverr  in  1; prdata  in  DATA_W

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs registered.
- IDLE: if any eligible req, select a winner, latch its write/addr/wdata/strb into the APB outputs, go to SETUP. Eligible = req[i] & ~rsp_valid[i] (masks the requester being answered this cycle).
- Round-robin: search starts at ptr and wraps modulo NUM_REQ; ptr ← winner+1 (wraps) on each grant. Reset ptr = 0.
- SETUP: psel=1, penable=0, go to ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata/pstrb stable for the whole transfer.
  - pready=1: rsp_valid[winner]=1 next cycle; rsp_err=pslverr; rsp_rdata=prdata for reads, 0 for writes; go to IDLE.
  - pready=0: wait counter +1; when counter == TIMEOUT (TIMEOUT≠0), complete with rsp_err=1, rsp_rdata=0, go to IDLE.
- pstrb is driven to 0 for reads. pslverr/prdata are ignored unless pready=1 in ACCESS.
- Requester rules: inputs stay stable from req rise until rsp_valid; req drops the cycle after rsp_valid. A requester dropping req early is illegal; the transfer still completes.
- Reset (any state, including mid-transfer): state=IDLE, ptr=0, counter=0. psel, penable, pwrite, paddr, pstrb, pwdata, rsp_valid, rsp_rdata, rsp_err and busy all 0. An aborted transfer gets no rsp_valid.

## Timing
- Request seen in IDLE at cycle 0 → SETUP cycle 1 → ACCESS cycle 2 → with pready=1 at cycle 2, rsp_valid and psel=0 at cycle 3.
- Zero-wait transfer is 3 cycles; each pready=0 cycle adds 1.
- Minimum spacing between transfers: one IDLE cycle (psel=0). The next SETUP follows at the earliest 2 cycles after the previous ACCESS end.
- Timeout fires on the cycle the counter reaches TIMEOUT, i.e. the ACCESS phase lasts at most TIMEOUT+1 cycles.
- rsp_valid is exactly one cycle wide, one-hot or zero.

## Structure
- Package apb_arb_pkg: state enum typedef (IDLE/SETUP/ACCESS), default APB_ADDR_W=12 and APB_DATA_W=32 constants, APB_STRB_W derived.
- Sub-module apb_rr_arbiter: inputs eligible vector and ptr; outputs one-hot grant, winner index and any-valid. Combinational pick; ptr register lives in the top.
- Top apb_master_arb: FSM, field latch, wait/timeout counter, response registers.

## Test plan
- Single write, req0 addr 0x004 data 0xA5A5_0001 strb 0xF, pready=1 immediately → psel at cycle 1, penable at cycle 2, rsp_valid=01 at cycle 3, rsp_err=0.
- Read with 2 wait states, prdata=0x0000_00C3 on pready → ACCESS lasts 3 cycles, rsp_rdata=0xC3, pstrb=0 throughout.
- Both requesters asserted continuously for 4 transfers → grant order 0,1,0,1, with one psel=0 cycle between each.
- pready held 0, TIMEOUT=16 → rsp_valid after 17 ACCESS cycles, rsp_err=1, rsp_rdata=0, psel drops.
- pslverr=1 with pready=1 on write → rsp_err=1; the next transfer then completes with rsp_err=0.
- reset asserted during ACCESS → next cycle all outputs 0, no rsp_valid; req1 pending at release is served first after req0, following ptr=0.
